seq_detect_prog: RTL and testbench

- Runtime-programmable serial pattern detector: pattern up to MAX_LEN bits, configurable length, overlapping or non-overlapping match mode.
- Adds input qualification, a saturating match counter and config-error reporting.
- Sits on a serial bit stream, e.g. a deserialiser output or framing/sync-word search.
- Default configuration detects 1011, non-overlapping.

---
 rtl/seq_detect_prog.sv | 112 +++++++++++
 tb/tb_seq_detect_prog.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with match counter and config-error flag.
// Optional per-bit compare mask enabled by defining SEQ_DETECT_PROG_MASK_EN.
module seq_detect_prog #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 LEN_W           = 4,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 DEFAULT_LEN     = 4,
    parameter bit                 DEFAULT_OVERLAP = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_bit,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef SEQ_DETECT_PROG_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    input  logic               cnt_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    // The oldest history bit would only ever be shifted out, so it is not stored.
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   len;
    logic [MAX_LEN-1:0] pattern;
    logic               overlap;
    logic [MAX_LEN-1:0] cmp_mask;
    logic [MAX_LEN-1:0] next_hist;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_inc;
    logic               fill_done;
    logic               pattern_hit;
    logic               match_now;
    logic               len_legal;

`ifdef SEQ_DETECT_PROG_MASK_EN
    logic [MAX_LEN-1:0] mask_q;
    assign cmp_mask = mask_q;
`else
    assign cmp_mask = '1;
`endif

    assign next_hist = {hist, in_bit};
    assign fill_inc  = {1'b0, fill} + (LEN_W+1)'(1);
    assign fill_done = (fill_inc >= {1'b0, len});

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len));
        end
    end

    assign pattern_hit = (((next_hist ^ pattern) & len_mask & cmp_mask) == '0);
    assign match_now   = in_valid && !cfg_load && fill_done && pattern_hit;
    assign len_legal   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (reset) begin
            hist      <= '0;
            fill      <= '0;
            len       <= LEN_W'(DEFAULT_LEN);
            pattern   <= DEFAULT_PATTERN;
            overlap   <= DEFAULT_OVERLAP;
`ifdef SEQ_DETECT_PROG_MASK_EN
            mask_q    <= '1;
`endif
            seq_seen  <= 1'b0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            seq_seen <= match_now;

            if (cfg_load) begin
                // An illegal length leaves the running search completely untouched.
                if (len_legal) begin
                    pattern <= cfg_pattern;
                    len     <= cfg_len;
                    overlap <= cfg_overlap;
`ifdef SEQ_DETECT_PROG_MASK_EN
                    mask_q  <= cfg_mask;
`endif
                    fill    <= '0;
                    hist    <= '0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (in_valid) begin
                hist <= next_hist[MAX_LEN-2:0];
                if (match_now) begin
                    fill <= overlap ? len : '0;
                end else begin
                    fill <= fill_done ? len : fill_inc[LEN_W-1:0];
                end
            end

            if (cnt_clr) begin
                match_cnt <= match_now ? CNT_W'(1) : '0;
            end else if (match_now && (match_cnt != '1)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomised, self-checking bench for seq_detect_prog against a queue-based reference model.
// Two instances share stimulus: default counter width and CNT_W=2 for saturation.
module tb_seq_detect_prog;

    logic       clk;
    logic       reset;
    logic       in_bit;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_mask;
    logic       cnt_clr;
    logic       seq_seen;
    logic [7:0] match_cnt;
    logic       cfg_err;
    logic       seq_seen2;
    logic [1:0] match_cnt2;
    logic       cfg_err2;

    int tests_run;
    int tests_failed;

    // Reference model state: accepted bits since the last restart, plus active config
    bit         mdl_q[$];
    logic [7:0] mdl_pat;
    logic [7:0] mdl_mask;
    int         mdl_len;
    bit         mdl_ovl;
    int         mdl_cnt;
    int         mdl_cnt2;
    bit         mdl_err;
    bit         exp_seen;

    seq_detect_prog dut (
        .clk         (clk),
        .reset       (reset),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
`ifdef SEQ_DETECT_PROG_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .cnt_clr     (cnt_clr),
        .seq_seen    (seq_seen),
        .match_cnt   (match_cnt),
        .cfg_err     (cfg_err)
    );

    seq_detect_prog #(.CNT_W(2)) dut_c2 (
        .clk         (clk),
        .reset       (reset),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
`ifdef SEQ_DETECT_PROG_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .cnt_clr     (cnt_clr),
        .seq_seen    (seq_seen2),
        .match_cnt   (match_cnt2),
        .cfg_err     (cfg_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_update();
        bit m;
        m = 1'b0;
        if (reset) begin
            mdl_pat  = 8'h0B;
            mdl_len  = 4;
            mdl_ovl  = 1'b0;
            mdl_mask = 8'hFF;
            mdl_q.delete();
            mdl_cnt  = 0;
            mdl_cnt2 = 0;
            mdl_err  = 1'b0;
            exp_seen = 1'b0;
            return;
        end
        if (cfg_load) begin
            if (cfg_len >= 1 && cfg_len <= 8) begin
                mdl_pat  = cfg_pattern;
                mdl_len  = int'(cfg_len);
                mdl_ovl  = cfg_overlap;
                mdl_mask = cfg_mask;
                mdl_q.delete();
            end else begin
                mdl_err = 1'b1;
            end
        end else if (in_valid) begin
            mdl_q.push_back(in_bit);
            while (mdl_q.size() > mdl_len) void'(mdl_q.pop_front());
            if (mdl_q.size() == mdl_len) begin
                m = 1'b1;
                for (int k = 0; k < mdl_len; k++) begin
                    if (mdl_mask[k] && (mdl_q[mdl_len-1-k] != mdl_pat[k])) m = 1'b0;
                end
                if (m && !mdl_ovl) mdl_q.delete();
            end
        end
        if (cnt_clr) begin
            mdl_cnt  = int'(m);
            mdl_cnt2 = int'(m);
        end else if (m) begin
            if (mdl_cnt < 255) mdl_cnt++;
            if (mdl_cnt2 < 3) mdl_cnt2++;
        end
        exp_seen = m;
    endtask

    // Advance one clock with the inputs currently driven, then settle past the edge
    task automatic applyStimulus();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        in_valid = 1'b1;
        in_bit   = b;
        applyStimulus();
        in_valid = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input bit ovl);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        applyStimulus();
        cfg_load    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (seq_seen !== 1'b0 || match_cnt !== 8'd0 || cfg_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: seen=%b cnt=%0d err=%b required 0/0/0", seq_seen, match_cnt, cfg_err);
        end
        tests_run++;
        if (match_cnt2 !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_cnt2: got %0d required 0", match_cnt2);
        end
    endtask

    task automatic test_default_stream();
        bit bits[7] = '{1, 0, 1, 1, 0, 1, 1};
        do_reset();
        foreach (bits[i]) begin
            send_bit(bits[i]);
            tests_run++;
            if (seq_seen !== exp_seen || seq_seen !== (i == 3)) begin
                tests_failed++;
                $display("[TB] FAIL default_seen bit%0d: got %b model %b", i + 1, seq_seen, exp_seen);
            end
        end
        tests_run++;
        if (match_cnt !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL default_cnt: got %0d required 1", match_cnt);
        end
    endtask

    task automatic test_overlap();
        bit bits[7] = '{1, 0, 1, 1, 0, 1, 1};
        do_reset();
        load_cfg(8'h0B, 4'd4, 1'b1);
        tests_run++;
        if (seq_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_seen: got %b required 0", seq_seen);
        end
        foreach (bits[i]) begin
            send_bit(bits[i]);
            tests_run++;
            if (seq_seen !== exp_seen || seq_seen !== (i == 3 || i == 6)) begin
                tests_failed++;
                $display("[TB] FAIL overlap_seen bit%0d: got %b model %b", i + 1, seq_seen, exp_seen);
            end
        end
        tests_run++;
        if (match_cnt !== 8'd2) begin
            tests_failed++;
            $display("[TB] FAIL overlap_cnt: got %0d required 2", match_cnt);
        end
    endtask

    task automatic test_gap();
        do_reset();
        send_bit(1); send_bit(0); send_bit(1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            tests_run++;
            if (seq_seen !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL gap_idle%0d: got %b required 0", i, seq_seen);
            end
        end
        send_bit(1);
        tests_run++;
        if (seq_seen !== 1'b1 || match_cnt !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL gap_match: seen=%b cnt=%0d required 1/1", seq_seen, match_cnt);
        end
        do_reset();
        send_bit(1); send_bit(0); send_bit(1);
        applyStimulus(); applyStimulus();
        do_reset();
        applyStimulus(); applyStimulus();
        send_bit(1);
        tests_run++;
        if (seq_seen !== 1'b0 || exp_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL gap_reset: seen=%b model=%b required 0", seq_seen, exp_seen);
        end
    endtask

    task automatic test_cfg_err();
        load_cfg(8'hFF, 4'd0, 1'b1);
        tests_run++;
        if (cfg_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL cfg_err_len0: got %b required 1", cfg_err);
        end
        load_cfg(8'hFF, 4'd9, 1'b1);
        applyStimulus();
        tests_run++;
        if (cfg_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL cfg_err_sticky: got %b required 1", cfg_err);
        end
        send_bit(1); send_bit(0); send_bit(1);
        tests_run++;
        if (seq_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL cfg_err_early: got %b required 0", seq_seen);
        end
        send_bit(1);
        tests_run++;
        if (seq_seen !== 1'b1 || exp_seen !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL cfg_err_oldpat: seen=%b model=%b required 1", seq_seen, exp_seen);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        load_cfg(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_bit(1);
            tests_run++;
            if (seq_seen !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL len1_seen%0d: got %b required 1", i, seq_seen);
            end
        end
        tests_run++;
        if (match_cnt2 !== 2'd3 || match_cnt !== 8'd5) begin
            tests_failed++;
            $display("[TB] FAIL saturate: cnt2=%0d cnt=%0d required 3/5", match_cnt2, match_cnt);
        end
        cnt_clr = 1'b1;
        send_bit(1);
        cnt_clr = 1'b0;
        tests_run++;
        if (match_cnt2 !== 2'd1 || match_cnt !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL clr_on_match: cnt2=%0d cnt=%0d required 1/1", match_cnt2, match_cnt);
        end
        send_bit(0);
        tests_run++;
        if (seq_seen !== 1'b0 || match_cnt !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL len1_zero: seen=%b cnt=%0d required 0/1", seq_seen, match_cnt);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r        = $urandom_range(0, 199);
            reset    = (r == 199);
            cfg_load = (r < 6);
            cnt_clr  = (r >= 6 && r < 12);
            in_valid = ($urandom_range(0, 9) < 8);
            in_bit   = 1'($urandom_range(0, 1));
            if (cfg_load) begin
                cfg_pattern = 8'($urandom);
                cfg_overlap = 1'($urandom_range(0, 1));
                cfg_len     = (r == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(1, 4));
            end
            applyStimulus();
            tests_run++;
            if (seq_seen !== exp_seen) begin
                tests_failed++;
                $display("[TB] FAIL rand_seen cyc%0d: got %b model %b", cyc, seq_seen, exp_seen);
            end
            tests_run++;
            if (match_cnt !== 8'(mdl_cnt) || match_cnt2 !== 2'(mdl_cnt2)) begin
                tests_failed++;
                $display("[TB] FAIL rand_cnt cyc%0d: got %0d/%0d model %0d/%0d", cyc, match_cnt, match_cnt2, mdl_cnt, mdl_cnt2);
            end
            tests_run++;
            if (cfg_err !== mdl_err) begin
                tests_failed++;
                $display("[TB] FAIL rand_err cyc%0d: got %b model %b", cyc, cfg_err, mdl_err);
            end
        end
        reset = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
    endtask

`ifdef SEQ_DETECT_PROG_MASK_EN
    task automatic test_mask();
        logic [3:0] streams[3] = '{4'b1011, 4'b1101, 4'b1001};
        foreach (streams[s]) begin
            do_reset();
            cfg_mask = 8'h09;
            load_cfg(8'h09, 4'd4, 1'b0);
            cfg_mask = 8'hFF;
            for (int i = 3; i >= 0; i--) send_bit(streams[s][i]);
            tests_run++;
            if (seq_seen !== 1'b1 || exp_seen !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL mask_stream%0d: seen=%b model=%b required 1", s, seq_seen, exp_seen);
            end
        end
        send_bit(0); send_bit(0); send_bit(1); send_bit(0);
        tests_run++;
        if (seq_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mask_nomatch: got %b required 0", seq_seen);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        in_bit       = 1'b0;
        in_valid     = 1'b0;
        cfg_load     = 1'b0;
        cfg_pattern  = 8'h00;
        cfg_len      = 4'd0;
        cfg_overlap  = 1'b0;
        cfg_mask     = 8'hFF;
        cnt_clr      = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_default_stream();
        test_overlap();
        test_gap();
        test_cfg_err();
        test_saturate();
`ifdef SEQ_DETECT_PROG_MASK_EN
        test_mask();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
